// File: rtl/interp2x2_stream.sv
// -----------------------------------------------------------------------------
// interp2x2_stream
//
// Streaming 2x2 neighbourhood filter for raster-ordered pixels. At most one
// pixel is accepted per clock. Each accepted pixel P at (row, col) is combined
// with its three upper/left neighbours and the result appears one clock later:
//
//        A = (r-1, c-1)   B = (r-1, c)
//        C = (r,   c-1)   D = P
//
// Modes (i_mode, sampled with the accepted pixel):
//   0 : floor average   (A+B+C+D) >> 2
//   1 : rounded average (A+B+C+D+2) >> 2
//   2 : maximum of A, B, C, D
//   3 : bypass D
// Pixels in row 0 or column 0 have no complete window. They produce o_data=0
// and o_border=1.
//
// Ports
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset
//   i_valid   input pixel qualifier (no backpressure)
//   i_data    input pixel, DATA_W bits
//   i_sof     start of frame, forces the accepted pixel to position (0,0)
//   i_mode    filter mode, 2 bits
//   o_valid   output qualifier, asserted one clock after each accepted pixel
//   o_data    filtered pixel, DATA_W bits (holds its value when o_valid=0)
//   o_border  output pixel lies in row 0 or column 0
// -----------------------------------------------------------------------------
module interp2x2_stream #(
    parameter int DATA_W     = 12,
    parameter int ROW_LENGTH = 640
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_sof,
    input  logic [1:0]        i_mode,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_border
);

    // The row above is delayed by ROW_LENGTH accepted pixels in total. The
    // RAM supplies ROW_LENGTH-1 of them. Its registered read port b_q
    // supplies the last one.
    localparam int LB_DEPTH = ROW_LENGTH - 1;
    localparam int PTR_W    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int COL_W    = $clog2(ROW_LENGTH);
    localparam int ROW_W    = 16;
    localparam int SUM_W    = DATA_W + 2;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LB_DEPTH - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LENGTH - 1);

    typedef enum logic [1:0] {
        MODE_FLOOR  = 2'd0,
        MODE_ROUND  = 2'd1,
        MODE_MAX    = 2'd2,
        MODE_BYPASS = 2'd3
    } mode_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] prev_q, prev_d;   // C: previous accepted pixel
    logic [DATA_W-1:0] a_q, a_d;         // A: line-buffer output delayed once
    logic [DATA_W-1:0] b_q;              // B: registered line-buffer read
    logic              o_valid_q, o_valid_d;
    logic [DATA_W-1:0] o_data_q, o_data_d;
    logic              o_border_q, o_border_d;

    logic [DATA_W-1:0] lb_mem [LB_DEPTH];

    // A pixel is only taken when reset is not also active. Reset wins and
    // the pixel is discarded.
    logic accept;
    assign accept = i_valid && !i_rst;

    // ------------------------------------------------------------------
    // Line buffer: read-before-write circular RAM. The word at ptr_q was
    // written LB_DEPTH accepts ago. Latching it into b_q makes it exactly
    // ROW_LENGTH accepts old when the next pixel arrives. Contents are
    // never cleared because row 0 of every frame refills them before use.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (accept) begin
            b_q             <= lb_mem[ptr_q];
            lb_mem[ptr_q]   <= i_data;
        end
    end

    // ------------------------------------------------------------------
    // Position of the pixel being accepted this cycle
    // ------------------------------------------------------------------
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             at_border;

    always_comb begin
        cur_col   = i_sof ? '0 : col_q;
        cur_row   = i_sof ? '0 : row_q;
        at_border = (cur_row == '0) || (cur_col == '0);
    end

    // ------------------------------------------------------------------
    // Window arithmetic
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] win_a, win_b, win_c, win_d;
    logic [SUM_W-1:0]  win_sum;
    logic [DATA_W-1:0] max_ab, max_cd, max_all;
    logic [DATA_W-1:0] filt;

    always_comb begin
        win_a = a_q;
        win_b = b_q;
        win_c = prev_q;
        win_d = i_data;

        // The sum is kept two bits wider than a pixel, so neither the sum
        // nor the +2 rounding term can overflow.
        win_sum = SUM_W'(win_a) + SUM_W'(win_b) + SUM_W'(win_c) + SUM_W'(win_d);

        max_ab  = (win_a > win_b) ? win_a : win_b;
        max_cd  = (win_c > win_d) ? win_c : win_d;
        max_all = (max_ab > max_cd) ? max_ab : max_cd;

        filt = '0;
        case (mode_e'(i_mode))
            MODE_FLOOR:  filt = DATA_W'(win_sum >> 2);
            // The largest result, (4*(2^DATA_W-1)+2)>>2, still fits DATA_W bits.
            MODE_ROUND:  filt = DATA_W'((win_sum + SUM_W'(2)) >> 2);
            MODE_MAX:    filt = max_all;
            MODE_BYPASS: filt = win_d;
            default:     filt = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic. Idle cycles change nothing except o_valid.
    // ------------------------------------------------------------------
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        ptr_d      = ptr_q;
        prev_d     = prev_q;
        a_d        = a_q;
        o_valid_d  = accept;
        o_data_d   = o_data_q;
        o_border_d = o_border_q;

        if (accept) begin
            // A row wrap sends the last column of row r to column 0 of
            // row r+1. The row counter sticks at all-ones.
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == '1) ? cur_row : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end

            ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
            prev_d = i_data;
            a_d    = b_q;

            o_border_d = at_border;
            o_data_d   = at_border ? '0 : filt;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q      <= '0;
            row_q      <= '0;
            ptr_q      <= '0;
            prev_q     <= '0;
            a_q        <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_border_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            ptr_q      <= ptr_d;
            prev_q     <= prev_d;
            a_q        <= a_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_border_q <= o_border_d;
        end
    end

    assign o_valid  = o_valid_q;
    assign o_data   = o_data_q;
    assign o_border = o_border_q;

endmodule

// File: tb/tb_interp2x2_stream.sv
// -----------------------------------------------------------------------------
// Testbench for interp2x2_stream (DATA_W=12, ROW_LENGTH=4).
// The reference model stores the current frame as a 2-D image indexed by
// (row, col). It forms each window directly from that image.
// -----------------------------------------------------------------------------
module tb_interp2x2_stream;

    localparam int DW = 12;
    localparam int RL = 4;
    localparam int MAX_ROWS = 512;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_sof = 1'b0;
    logic [1:0]    i_mode = 2'd0;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_border;

    always #5 clk = ~clk;

    interp2x2_stream #(.DATA_W(DW), .ROW_LENGTH(RL)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_sof   (i_sof),
        .i_mode  (i_mode),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_border(o_border)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    int            m_row = 0, m_col = 0;
    int            last_r = 0, last_c = 0;
    logic [DW-1:0] frame [MAX_ROWS][RL];
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data = '0;
    logic          exp_border = 1'b0;
    logic [DW-1:0] got [4][4];

    function automatic void model_reset();
        m_row = 0; m_col = 0;
        exp_valid = 1'b0; exp_data = '0; exp_border = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input logic [DW-1:0] d,
                                       input logic s, input logic [1:0] m);
        int r, c, a, b, cc, dd, sum, mx;
        if (!v) begin
            exp_valid = 1'b0;       // data and border hold
            return;
        end
        r = s ? 0 : m_row;
        c = s ? 0 : m_col;
        frame[r][c] = d;
        last_r = r; last_c = c;
        exp_valid = 1'b1;
        if (r == 0 || c == 0) begin
            exp_data = '0; exp_border = 1'b1;
        end else begin
            a = int'(frame[r-1][c-1]); b = int'(frame[r-1][c]);
            cc = int'(frame[r][c-1]); dd = int'(d);
            sum = a + b + cc + dd;
            mx = a;
            if (b > mx) mx = b;
            if (cc > mx) mx = cc;
            if (dd > mx) mx = dd;
            case (m)
                2'd0: exp_data = DW'(sum / 4);
                2'd1: exp_data = DW'((sum + 2) / 4);
                2'd2: exp_data = DW'(mx);
                default: exp_data = d;
            endcase
            exp_border = 1'b0;
        end
        if (c == RL - 1) begin
            m_col = 0;
            m_row = (r < MAX_ROWS - 1) ? r + 1 : r;
        end else begin
            m_col = c + 1;
            m_row = r;
        end
    endfunction

    // Drive one cycle of stimulus, then sample 1 ns after the capturing edge.
    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic s, input logic [1:0] m);
        @(negedge clk);
        i_valid = v; i_data = d; i_sof = s; i_mode = m;
        model_step(v, d, s, m);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        i_rst = 1'b1; i_valid = 1'b1; i_data = DW'($urandom); i_sof = 1'b0;
        @(posedge clk); #1;
        model_reset();
        n_checks++;
        if (o_valid !== 1'b0 || o_data !== '0 || o_border !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got v=%b d=%0d b=%b, expected v=0 d=0 b=0",
                     o_valid, o_data, o_border);
        end
        @(negedge clk);
        i_rst = 1'b0; i_valid = 1'b0;
        step(1'b0, '0, 1'b0, 2'd0);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got v=%b expected v=0", o_valid);
        end
    endtask

    task automatic test_basic_avg();
        int pulses = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b1, DW'(4*r + c), 1'b0, 2'd0);
                if (o_valid === 1'b1) pulses++;
                got[r][c] = o_data;
                n_checks++;
                if (o_valid !== exp_valid || o_data !== exp_data || o_border !== exp_border) begin
                    n_fail++;
                    $display("FAIL basic (%0d,%0d): got v=%b d=%0d b=%b expected v=%b d=%0d b=%b",
                             r, c, o_valid, o_data, o_border, exp_valid, exp_data, exp_border);
                end
            end
        end
        n_checks++;
        if (pulses != 16) begin
            n_fail++;
            $display("FAIL basic_pulses: got %0d expected 16", pulses);
        end
        n_checks++;
        if (got[1][1] !== 12'd2 || got[2][2] !== 12'd7 || got[3][3] !== 12'd12) begin
            n_fail++;
            $display("FAIL basic_spots: got %0d/%0d/%0d expected 2/7/12",
                     got[1][1], got[2][2], got[3][3]);
        end
    endtask

    task automatic test_modes();
        for (int m = 1; m < 4; m++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    step(1'b1, DW'(4*r + c), (r == 0 && c == 0), 2'(m));
                    got[r][c] = o_data;
                    n_checks++;
                    if (o_valid !== exp_valid || o_data !== exp_data || o_border !== exp_border) begin
                        n_fail++;
                        $display("FAIL mode%0d (%0d,%0d): got v=%b d=%0d b=%b expected v=%b d=%0d b=%b",
                                 m, r, c, o_valid, o_data, o_border, exp_valid, exp_data, exp_border);
                    end
                end
            end
            n_checks++;
            if ((m == 1 && (got[1][1] !== 12'd3  || got[3][3] !== 12'd13)) ||
                (m == 2 && (got[2][2] !== 12'd10 || got[3][1] !== 12'd13)) ||
                (m == 3 && (got[2][3] !== 12'd11 || got[0][2] !== 12'd0))) begin
                n_fail++;
                $display("FAIL mode%0d_spots: got (1,1)=%0d (2,2)=%0d (3,3)=%0d (3,1)=%0d (2,3)=%0d (0,2)=%0d",
                         m, got[1][1], got[2][2], got[3][3], got[3][1], got[2][3], got[0][2]);
            end
        end
    endtask

    task automatic test_idle_gaps();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b1, DW'(4*r + c), (r == 0 && c == 0), 2'd0);
                got[r][c] = o_data;
                n_checks++;
                if (o_valid !== exp_valid || o_data !== exp_data || o_border !== exp_border) begin
                    n_fail++;
                    $display("FAIL gaps (%0d,%0d): got v=%b d=%0d b=%b expected v=%b d=%0d b=%b",
                             r, c, o_valid, o_data, o_border, exp_valid, exp_data, exp_border);
                end
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, DW'($urandom), 1'b1, 2'($urandom));
                    n_checks++;
                    if (o_valid !== 1'b0 || o_data !== exp_data || o_border !== exp_border) begin
                        n_fail++;
                        $display("FAIL gap_hold (%0d,%0d,%0d): got v=%b d=%0d b=%b expected v=0 d=%0d b=%b",
                                 r, c, g, o_valid, o_data, o_border, exp_data, exp_border);
                    end
                end
            end
        end
        n_checks++;
        if (got[1][1] !== 12'd2 || got[2][2] !== 12'd7 || got[3][3] !== 12'd12) begin
            n_fail++;
            $display("FAIL gaps_spots: got %0d/%0d/%0d expected 2/7/12",
                     got[1][1], got[2][2], got[3][3]);
        end
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b1, 12'hFFF, (r == 0 && c == 0), 2'd1);
                n_checks++;
                if (o_valid !== 1'b1 || o_data !== ((r == 0 || c == 0) ? 12'd0 : 12'hFFF) ||
                    o_data !== exp_data) begin
                    n_fail++;
                    $display("FAIL saturate (%0d,%0d): got v=%b d=%0d expected v=1 d=%0d",
                             r, c, o_valid, o_data, exp_data);
                end
            end
        end
    endtask

    task automatic test_resync();
        // Rows 0 and 1, then (2,0). The pixel at (2,1) arrives with i_sof.
        for (int k = 0; k < 9; k++) begin
            step(1'b1, DW'(100 + k), (k == 0), 2'd0);
        end
        step(1'b1, DW'(500), 1'b1, 2'd0);
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== 12'd0 || o_border !== 1'b1) begin
            n_fail++;
            $display("FAIL resync_sof: got v=%b d=%0d b=%b expected v=1 d=0 b=1",
                     o_valid, o_data, o_border);
        end
        // Continue the restarted frame: row 0 (three more) then row 1.
        for (int k = 0; k < 7; k++) begin
            step(1'b1, DW'($urandom), 1'b0, 2'd0);
            n_checks++;
            if (o_valid !== exp_valid || o_data !== exp_data || o_border !== exp_border) begin
                n_fail++;
                $display("FAIL resync_after (%0d,%0d): got v=%b d=%0d b=%b expected v=%b d=%0d b=%b",
                         last_r, last_c, o_valid, o_data, o_border, exp_valid, exp_data, exp_border);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 10; k++) begin
            step(1'b1, DW'($urandom), (k == 0), 2'd0);
        end
        // Reset coincides with a valid pixel: the pixel must be discarded.
        @(negedge clk);
        i_rst = 1'b1; i_valid = 1'b1; i_data = 12'd777; i_sof = 1'b0;
        @(posedge clk); #1;
        model_reset();
        n_checks++;
        if (o_valid !== 1'b0 || o_data !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b d=%0d expected v=0 d=0", o_valid, o_data);
        end
        @(negedge clk);
        i_rst = 1'b0; i_valid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b1, DW'(4*r + c), 1'b0, 2'd0);
                got[r][c] = o_data;
                n_checks++;
                if (o_valid !== exp_valid || o_data !== exp_data || o_border !== exp_border) begin
                    n_fail++;
                    $display("FAIL reset_frame (%0d,%0d): got v=%b d=%0d b=%b expected v=%b d=%0d b=%b",
                             r, c, o_valid, o_data, o_border, exp_valid, exp_data, exp_border);
                end
            end
        end
        n_checks++;
        if (got[1][1] !== 12'd2 || got[2][2] !== 12'd7 || got[3][3] !== 12'd12) begin
            n_fail++;
            $display("FAIL reset_spots: got %0d/%0d/%0d expected 2/7/12",
                     got[1][1], got[2][2], got[3][3]);
        end
    endtask

    task automatic test_random();
        logic v, s;
        step(1'b1, DW'($urandom), 1'b1, 2'($urandom));
        for (int k = 0; k < 300; k++) begin
            v = ($urandom_range(3, 0) != 0);
            s = v && ($urandom_range(19, 0) == 0);
            step(v, DW'($urandom), s, 2'($urandom));
            n_checks++;
            if (o_valid !== exp_valid || o_data !== exp_data || o_border !== exp_border) begin
                n_fail++;
                $display("FAIL random #%0d: got v=%b d=%0d b=%b expected v=%b d=%0d b=%b",
                         k, o_valid, o_data, o_border, exp_valid, exp_data, exp_border);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_basic_avg();
        test_modes();
        test_idle_gaps();
        test_saturation();
        test_resync();
        test_reset_mid();
        test_random();
        step(1'b0, '0, 1'b0, 2'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interp2x2_stream.md
Name: interp2x2_stream

Overview:
- Streaming 2x2 neighbourhood filter for raster-ordered pixel data.
- Parametrised successor of the 2x2 averaging interpolator: generalised pixel width and row length.
- Adds runtime-selectable modes, an explicit output valid, a border flag and start-of-frame resynchronisation.
- Sits between the sensor/pixel capture stage and downstream colour/grey conversion; one pixel per clock maximum.

Parameters:
- DATA_W, 12, pixel width in bits (>= 2).
- ROW_LENGTH, 640, pixels per row (>= 2); sets line-buffer depth (ROW_LENGTH-1 entries) and column counter range.

Ports:
- i_clk  in  1  clock; all logic rising-edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  input pixel qualifier; pixel accepted on any clock with i_valid=1 (no backpressure).
- i_data  in  DATA_W  input pixel.
- i_sof  in  1  start of frame; meaningful only with i_valid=1.
- i_mode  in  2  filter mode, sampled with each accepted pixel.
- o_valid  out  1  output pixel qualifier.
- o_data  out  DATA_W  filtered pixel.
- o_border  out  1  output pixel is in row 0 or column 0.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - o_valid=0, o_data=0, o_border=0.
  - Column and row counters cleared to 0; previous-pixel register cleared to 0.
  - Line buffer contents need not be cleared; they are never used before being rewritten.
  - Reset mid-row aborts the frame; the next accepted pixel is position (0,0).
- Position tracking:
  - col counts 0..ROW_LENGTH-1 and wraps to 0.
  - row increments on each col wrap and saturates at all-ones.
  - An accepted pixel with i_sof=1 is forced to position (0,0) regardless of counter state; counters then advance from there.
  - i_sof with i_valid=0 is ignored.
- Window for the accepted pixel P at (r,c):
  - A = pixel at (r-1,c-1), B = (r-1,c), C = (r,c-1), D = P.
  - B is read from the line buffer (pixel written ROW_LENGTH accepted pixels earlier).
  - A is a one-pixel delayed copy of the line-buffer output.
  - C is the previous accepted pixel.
  - Line buffer and delay registers advance only on accepted pixels; idle cycles (i_valid=0) change no state except o_valid.
- Latency: exactly 1 clock. Each accepted pixel produces o_valid=1 on the next clock.
  - o_valid=0 on clocks following a non-accepted cycle; o_data and o_border hold their last values.
- Border: if r==0 or c==0, o_data=0 and o_border=1. Otherwise o_border=0 and o_data follows i_mode.
- Modes; sum S = A+B+C+D computed at DATA_W+2 bits, so no overflow:
  - 0: floor average, S>>2.
  - 1: rounded average, (S+2)>>2, computed at DATA_W+2 bits. The maximum result is 2^DATA_W - 1, so it fits DATA_W and needs no saturation.
  - 2: maximum of A,B,C,D.
  - 3: bypass, o_data=D; still border-zeroed.
- Simultaneous i_rst and i_valid: reset wins; the pixel is discarded.
- Row wrap: column ROW_LENGTH-1 of row r is followed by column 0 of row r+1 (a border pixel). C for column 1 is column 0 of the same row, never the previous row's last pixel.

Test Plan:
- Basic average: ROW_LENGTH=4, DATA_W=12, mode 0, pixels img[r][c]=4r+c streamed back to back for 4 rows.
  - Expect 16 o_valid pulses, each 1 clock after input.
  - (1,1)=2, (2,2)=7, (3,3)=12; all row-0 and col-0 outputs 0 with o_border=1.
- Rounded and max: same image.
  - Mode 1: (1,1)=3, (3,3)=13.
  - Mode 2: (2,2)=10, (3,1)=13.
  - Mode 3: (2,3)=11, (0,2)=0.
- Idle gaps: same image with i_valid low for 3 clocks after every pixel.
  - Outputs are identical to the basic-average values.
  - o_valid=0 during gaps; o_data holds its last value.
- Saturation corner: mode 1, all pixels 4095.
  - Every non-border output is 4095; no wrap to 0.
- Resync and reset:
  - Assert i_sof with the pixel at (2,1): that output is 0 with o_border=1 and row/col restart at (0,0).
  - Separately, assert i_rst mid-row 2: next clock o_valid=0 and o_data=0; the following 4x4 frame reproduces the basic-average values exactly.
